// File: rtl/booth_if.sv
// -----------------------------------------------------------------------------
// booth_if
// Bundle of the operand/start inputs and result/status outputs exchanged
// between the switch/press-detector stage and the Booth multiplier controller.
//   start         level start request (held high by the press detector)
//   multiplicand  signed operand M, N bits
//   multiplier    signed operand Q, N bits
//   product       signed 2N-bit result, registered
//   busy          multiply in progress
//   done          one-cycle pulse when the result is published
//   valid         product matches the most recently started operands
//   step          iterations remaining (debug LEDs)
// Modports: master drives start/operands, slave is the multiplier controller.
// -----------------------------------------------------------------------------
interface booth_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic              start;
    logic [N-1:0]      multiplicand;
    logic [N-1:0]      multiplier;
    logic [2*N-1:0]    product;
    logic              busy;
    logic              done;
    logic              valid;
    logic [CW-1:0]     step;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, done, valid, step
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, done, valid, step
    );
endinterface

// File: rtl/booth_control.sv
// -----------------------------------------------------------------------------
// booth_control
// Radix-2 signed Booth multiplier: controller plus datapath. One Booth
// iteration per clock, so a multiply occupies N+1 cycles from the start edge
// to the done pulse. Only rising edges of the (possibly long-held) start level
// launch a multiply; edges seen while busy are consumed and dropped.
// Ports:
//   Clk_100M  system clock
//   reset     asynchronous, active-high reset
//   bus       booth_if slave: start/operands in, product/busy/done/valid/step out
// -----------------------------------------------------------------------------
module booth_control #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic     Clk_100M,
    input  logic     reset,
    booth_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic            start_d_q;
    logic [N:0]      a_q;
    logic [N:0]      m_q;
    logic [N-1:0]    q_q;
    logic            q1_q;
    logic [CW-1:0]   step_q;
    logic [2*N-1:0]  product_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;

    // Next-iteration datapath values
    logic [N:0]      sum_d;
    logic [N:0]      a_d;
    logic [N-1:0]    q_d;
    logic            q1_d;
    logic            start_edge_s;

    assign start_edge_s = bus.start & ~start_d_q;

    // Booth add/subtract followed by arithmetic shift right of {A,Q,Q_1}
    always_comb begin
        sum_d = a_q;
        case ({q_q[0], q1_q})
            2'b01:   sum_d = a_q + m_q;
            2'b10:   sum_d = a_q - m_q;
            default: sum_d = a_q;
        endcase
        // A is one bit wider than the operands, so sum_d[N] is the true sign
        a_d  = {sum_d[N], sum_d[N:1]};
        q_d  = {sum_d[0], q_q[N-1:1]};
        q1_d = q_q[0];
    end

    // Controller FSM with datapath registers and registered status outputs
    always_ff @(posedge Clk_100M or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            start_d_q <= 1'b0;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            step_q    <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            // Tracked in every state so a press during a multiply is consumed
            start_d_q <= bus.start;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_edge_s) begin
                        m_q     <= {bus.multiplicand[N-1], bus.multiplicand};
                        q_q     <= bus.multiplier;
                        a_q     <= '0;
                        q1_q    <= 1'b0;
                        step_q  <= CW'(N);
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    a_q    <= a_d;
                    q_q    <= q_d;
                    q1_q   <= q1_d;
                    step_q <= step_q - CW'(1);
                    if (step_q == CW'(1)) begin
                        // Low 2N bits of the shifted {A,Q}; A's extra bit is only sign
                        product_q <= {a_d[N-1:0], q_d};
                        state_q   <= DONE;
                    end else begin
                        state_q   <= CALC;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.valid   = valid_q;
    assign bus.step    = step_q;

endmodule
